// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared state encoding, digit width and sizing helper for the BCD converter
package bin2bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic longint unsigned pow10(input int n);
        longint unsigned p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble digit correction, adds 3 when the digit is 5 or more
module bcd_add3
    import bin2bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] d,
    output logic [BCD_DIGIT_W-1:0] q
);

    assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary to BCD converter with valid/ready handshakes
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BIN_W-1:0]              bin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic [DIGITS-1:0]             blank,
    output logic                          busy
);

    localparam int CW = $clog2(BIN_W + 1);
    localparam int AW = BCD_DIGIT_W * DIGITS;

    if (BIN_W < 4 || pow10(DIGITS) <= (64'd1 << BIN_W) - 64'd1) begin : g_bad_params
        $error("bin2bcd_seq: BIN_W must be >= 4 and DIGITS must cover 2**BIN_W-1");
    end

    state_t            state, state_n;
    logic [CW-1:0]     cnt;
    logic [BIN_W-1:0]  sr, sr_n;
    logic [AW-1:0]     acc, adj, acc_n;
    logic [AW+BIN_W-1:0] step;
    logic [DIGITS-1:0] blank_n;
    logic              zero_run;
    logic              accept, last;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .d(acc[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .q(adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    assign step  = {adj, sr} << 1;
    assign acc_n = step[AW+BIN_W-1:BIN_W];
    assign sr_n  = step[BIN_W-1:0];

    assign in_ready  = (state == IDLE);
    assign busy      = (state == SHIFT);
    assign out_valid = (state == DONE);
    assign accept    = in_ready && in_valid;
    assign last      = (cnt == CW'(1));

    // Blank a digit only when it and every more significant digit are zero; digit 0 always shows.
    always_comb begin
        blank_n  = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run   = zero_run && (acc_n[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
            blank_n[i] = zero_run;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = in_valid ? SHIFT : IDLE;
            SHIFT:   state_n = last ? DONE : SHIFT;
            DONE:    state_n = out_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            sr    <= '0;
            acc   <= '0;
            bcd   <= '0;
            blank <= ~DIGITS'(1);
        end else if (accept) begin
            cnt <= CW'(BIN_W);
            sr  <= bin;
            acc <= '0;
        end else if (busy) begin
            cnt <= cnt - CW'(1);
            sr  <= sr_n;
            acc <= acc_n;
            if (last) begin
                bcd   <= acc_n;
                blank <= blank_n;
            end
        end
    end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL have parameter BIN_W, default 8, binary input width (>=4).
REQ-002 SHALL have parameter DIGITS, default 3, BCD output digit count; elaboration SHALL fail unless 10**DIGITS > 2**BIN_W-1.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  bin holds a conversion request.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port bin  input  BIN_W  unsigned binary value.
REQ-008 SHALL have port out_valid  output  1  bcd/blank hold a finished result.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port bcd  output  4*DIGITS  packed BCD, digit 0 in bits [3:0] (least significant).
REQ-011 SHALL have port blank  output  DIGITS  bit i=1 when digit i is a leading zero (for 7-seg blanking).
REQ-012 SHALL have port busy  output  1  conversion in progress.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE, registered state only.
REQ-014 SHALL drive in_ready=1 only in IDLE; busy=1 only in SHIFT; out_valid=1 only in DONE.
REQ-015 SHALL accept on the edge where in_valid && in_ready: capture bin into the shift register, clear BCD accumulator, load step counter with BIN_W, go to SHIFT.
REQ-016 SHALL ignore changes on bin after acceptance.
REQ-017 SHALL perform one double-dabble step per SHIFT cycle: every accumulator digit >=5 gets +3 (4-bit, no carry out), then {accumulator, shift register} shifts left one bit.
REQ-018 SHALL decrement the counter each step and move to DONE on the edge that completes step BIN_W; out_valid SHALL rise exactly BIN_W cycles after the accept edge.
REQ-019 SHALL register bcd and blank on SHIFT->DONE and hold them stable while out_valid && !out_ready.
REQ-020 SHALL return to IDLE on the edge where out_valid && out_ready; bcd/blank keep last value until next DONE.
REQ-021 SHALL compute blank[i]=1 iff digits i..DIGITS-1 are all zero, for i>=1; blank[0] SHALL always be 0 (value 0 shows one "0").
REQ-022 SHALL NOT accept a new request in the same cycle a result is consumed (in_ready low in DONE); back-to-back throughput is BIN_W+2 cycles.
REQ-023 SHALL produce correct results for bin=0 and bin=2**BIN_W-1.

Reset
REQ-024 SHALL on rst_n low immediately force state IDLE, counter 0, shift register 0, bcd 0, blank all-ones except bit 0, out_valid 0, busy 0, in_ready 1.
REQ-025 SHALL abandon any conversion in progress when reset asserts mid-SHIFT or mid-DONE; no partial result SHALL appear after release.
REQ-026 SHALL accept a request on the first rising edge after rst_n deasserts.

Structure
REQ-027 SHALL place state enum (IDLE/SHIFT/DONE) and BCD_DIGIT_W=4 in package bin2bcd_pkg.
REQ-028 SHALL use one sub-module bcd_add3 (4-bit in/out, combinational +3 when >=5), instantiated DIGITS times via generate.
REQ-029 SHALL size the counter as $clog2(BIN_W+1) bits.

Verification
REQ-030 BIN_W=4, DIGITS=2, bin=15 -> bcd=8'h15, blank=2'b00, out_valid 4 cycles after accept.
REQ-031 BIN_W=8, DIGITS=3, bin=255 -> bcd=12'h255, blank=3'b000; bin=7 -> bcd=12'h007, blank=3'b110; bin=0 -> bcd=12'h000, blank=3'b110.
REQ-032 bin=128, out_ready low 5 cycles after out_valid -> bcd=12'h128 stable, in_ready low throughout, IDLE one cycle after out_ready high.
REQ-033 bin=200 accepted, rst_n pulsed low at step 4 -> outputs at reset values, next request bin=42 -> bcd=12'h042.
REQ-034 bin changed to 99 one cycle after accepting 250 -> bcd=12'h250.
REQ-035 Exhaustive BIN_W=8 sweep 0..255 with random out_ready stalls -> every bcd equals decimal digits of bin, no result lost or duplicated.
